// File: rtl/dmem_slave.sv
// Byte-serial data memory for the pipeline memory stage: 8-byte little-endian
// loads/stores behind valid/ready request and response channels, with range errors.
module dmem_slave #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned CNT_W = 3
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [63:0] resp_rdata_o,
   output logic        resp_error_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;
   logic             error_q, error_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      rdata_q, rdata_d;
   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    byte_addr;
   logic             mem_we;
   logic [7:0]       mem_wbyte;

   // Legal addresses never exceed DEPTH-8, so addr_q + k cannot wrap.
   assign byte_addr = addr_q + AW'(cnt_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      write_d   = write_q;
      error_d   = error_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      mem_we    = 1'b0;
      mem_wbyte = wdata_q[{cnt_q, 3'b000} +: 8];
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i[AW-1:0];
               wdata_d = req_wdata_i;
               rdata_d = '0;
               if (req_addr_i > 64'(DEPTH - 8)) begin
                  error_d = 1'b1;
                  state_d = StResp;
               end else begin
                  error_d = 1'b0;
                  cnt_d   = '0;
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            if (write_q) begin
               mem_we = 1'b1;
            end else begin
               rdata_d[{cnt_q, 3'b000} +: 8] = mem_q[byte_addr];
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {CNT_W{1'b1}}) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (resp_ready_i) begin
               rdata_d = '0;
               error_d = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         write_q <= 1'b0;
         error_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         error_q <= error_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         if (mem_we) begin
            mem_q[byte_addr] <= mem_wbyte;
         end
      end
   end

   // Gated by reset so neither channel handshakes during the reset cycle.
   assign req_ready_o  = rstn_i && (state_q == StIdle);
   assign resp_valid_o = rstn_i && (state_q == StResp);
   assign resp_rdata_o = rdata_q;
   assign resp_error_o = error_q;

endmodule

// File: tb/tb_dmem_slave.sv
// Bench for dmem_slave: directed cases plus random loads/stores checked against
// a byte-array reference model of the memory.
module tb_dmem_slave;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_write;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_error;
   logic [63:0] resp_rdata;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   dmem_slave #(.DEPTH(DEPTH), .CNT_W(3)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .resp_valid_o(resp_valid),
      .resp_ready_i(resp_ready),
      .resp_rdata_o(resp_rdata),
      .resp_error_o(resp_error)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
   endtask

   // Reference: an 8-byte little-endian word in a flat byte array, errors leave it untouched.
   task automatic model_txn(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                            output logic [63:0] rd, output bit err);
      err = (addr > 64'(DEPTH - 8));
      rd  = '0;
      if (!err) begin
         for (int k = 0; k < 8; k++) begin
            if (wr) model_mem[int'(addr) + k] = wdata[8*k +: 8];
            else    rd[8*k +: 8] = model_mem[int'(addr) + k];
         end
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      step();
      check("ready_in_reset", {63'd0, req_ready}, 64'd0);
      rstn = 1'b1;
      step();
      clear_model();
      check("ready_after_reset", {63'd0, req_ready}, 64'd1);
      check("valid_after_reset", {63'd0, resp_valid}, 64'd0);
      check("rdata_after_reset", resp_rdata, 64'd0);
      check("error_after_reset", {63'd0, resp_error}, 64'd0);
   endtask

   // One full transaction: accept, wait for response, hold backpressure, handshake.
   task automatic txn(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                      input int hold);
      logic [63:0] exp_rd;
      bit          exp_err;
      int          n;
      model_txn(wr, addr, wdata, exp_rd, exp_err);
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      step();
      req_valid = 1'b0;
      // n counts edges after the accept edge until resp_valid is seen.
      n = 0;
      while (resp_valid !== 1'b1 && n < 40) begin
         req_addr  = {$urandom, $urandom};
         req_wdata = {$urandom, $urandom};
         req_write = 1'($urandom_range(0, 1));
         req_valid = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      check("latency", 64'(n), exp_err ? 64'd0 : 64'd8);
      check("resp_valid", {63'd0, resp_valid}, 64'd1);
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_error", {63'd0, resp_error}, {63'd0, exp_err});
      check("ready_in_resp", {63'd0, req_ready}, 64'd0);
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_valid", {63'd0, resp_valid}, 64'd1);
         check("hold_rdata", resp_rdata, exp_rd);
         check("hold_ready", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check("post_valid", {63'd0, resp_valid}, 64'd0);
      check("post_ready", {63'd0, req_ready}, 64'd1);
      check("post_rdata", resp_rdata, 64'd0);
      check("post_error", {63'd0, resp_error}, 64'd0);
   endtask

   initial begin
      logic [63:0] a;
      int          st;
      rstn       = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      clear_model();
      step();
      do_reset();

      txn(1'b0, 64'h10, 64'h0, 0);
      txn(1'b1, 64'h20, 64'h0123456789ABCDEF, 0);
      txn(1'b0, 64'h20, 64'h0, 0);
      txn(1'b0, 64'h21, 64'h0, 0);
      txn(1'b1, 64'd1016, 64'hFFFFFFFFFFFFFFFF, 0);
      txn(1'b0, 64'd1016, 64'h0, 0);
      txn(1'b0, 64'd1017, 64'h0, 0);
      txn(1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 0);
      txn(1'b1, 64'd2000, 64'h1122334455667788, 0);
      txn(1'b0, 64'd1016, 64'h0, 0);
      txn(1'b0, 64'h20, 64'h0, 5);

      // Reset sampled at the edge that would transfer byte 3 of a store to 0x40.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'h40;
      req_wdata = 64'hA5A5A5A5A5A5A5A5;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      do_reset();
      txn(1'b0, 64'h40, 64'h0, 0);
      txn(1'b0, 64'h20, 64'h0, 0);

      for (int t = 0; t < 60; t++) begin
         st = int'($urandom_range(0, 9));
         if (st == 0)      a = {$urandom, $urandom};
         else if (st < 3)  a = 64'($urandom_range(1000, 1030));
         else              a = 64'($urandom_range(0, 96));
         txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
